// File: rtl/rs232_pkg.sv
// Shared constants and state encoding for the RS-232 receive path.
package rs232_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for an asynchronous serial line plus falling-edge detect.
module rs232_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic prev;

    // Flops reset to the idle-high level so a quiet line never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            prev <= rx_s;
        end
    end

    assign fall = prev & ~rx_s;

endmodule

// File: rtl/rs232_rx.sv
// RS-232 receiver, 8N1 LSB first, majority-voted bit centres, one-entry valid/ready output.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 870,
    parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] HALF_AT  = CNT_W'(HALF_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

    state_t                 state;
    state_t                 next_state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       tgt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   s0;
    logic                   s1;
    logic                   rx_s;
    logic                   fall;
    logic                   at_tgt;
    logic                   vote;
    logic                   byte_done;
    logic                   stop_bad;

    rs232_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    // START resolves half a bit after the edge; every later bit one full period after the previous one.
    assign tgt    = (state == START) ? HALF_AT : BIT_LAST;
    assign at_tgt = (cnt == tgt);
    assign vote   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fall) next_state = START;
            START:   if (at_tgt) next_state = vote ? IDLE : DATA;
            DATA:    if (at_tgt && bit_idx == 3'(DATA_BITS - 1)) next_state = STOP;
            STOP:    if (at_tgt) next_state = vote ? IDLE : BREAK;
            BREAK:   if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        byte_done = (state == STOP) && at_tgt && vote;
        stop_bad  = (state == STOP) && at_tgt && !vote;
    end

    // Two samples before the resolve point are stored; the third is the live rx_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
        end else begin
            if (state == IDLE || state == BREAK || at_tgt) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == tgt - CNT_W'(2)) begin
                s0 <= rx_s;
            end
            if (cnt == tgt - CNT_W'(1)) begin
                s1 <= rx_s;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && at_tgt) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == DATA && at_tgt) begin
                shift <= {vote, shift[DATA_BITS-1:1]};
            end
        end
    end

    // A completed byte only replaces the held one when the consumer takes it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && valid && !ready;
            if (byte_done && (!valid || ready)) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
